// File: rtl/riscv_pkg.sv
// Shared core parameters plus the program loader's state type and field widths.
package riscv_pkg;

    localparam int SIZE       = 1024;  // BRAM depth in 32-bit words
    localparam int ADDR_WIDTH = 10;    // word-address width
    localparam int NB_COL     = 4;     // byte lanes per word
    localparam int COL_WIDTH  = 8;     // bits per lane

    localparam int LOADER_LEN_W  = 16;
    localparam int LOADER_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/bram_loader.sv
// Framed byte-stream program loader: writes the payload into the BRAM one byte
// lane per accepted byte, and keeps the core in reset until a frame with a good
// XOR checksum has been fully written.
module bram_loader
    import riscv_pkg::*;
#(
    parameter int MEM_SIZE = SIZE,
    parameter int MEM_AW   = ADDR_WIDTH,
    parameter int LANES    = NB_COL,
    parameter int LANE_W   = COL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load_start,
    input  logic [LOADER_BYTE_W-1:0]  in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES-1:0]          mem_we,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [LANES*LANE_W-1:0]   mem_wdata,
    output logic                      core_hold,
    output logic                      load_done,
    output logic                      load_err
);

    localparam int BI_W = (LANES > 1) ? $clog2(LANES) : 1;

    loader_state_t              state;
    logic [MEM_AW:0]            word_idx;   // one extra bit so N == MEM_SIZE fits
    logic [BI_W-1:0]            byte_idx;
    logic [LOADER_LEN_W-1:0]    len;
    logic [LOADER_BYTE_W-1:0]   csum;

    logic                       accept;
    logic                       lane_last;
    logic                       last_byte;
    logic [MEM_AW:0]            word_nxt;
    logic [LOADER_LEN_W-1:0]    len_full;
    logic                       oversize;

    // Ready depends only on state and start; a start pulse always blocks the byte.
    always_comb begin
        in_ready = 1'b0;
        if (!load_start) begin
            case (state)
                LEN0, LEN1, DATA, CSUM, ERR: in_ready = 1'b1;
                default:                     in_ready = 1'b0;
            endcase
        end
    end

    assign accept    = in_valid && in_ready;
    assign word_nxt  = word_idx + (MEM_AW+1)'(1);
    assign lane_last = (byte_idx == BI_W'(LANES-1));
    assign last_byte = lane_last && (LOADER_LEN_W'(word_nxt) == len);
    assign len_full  = {in_data, len[7:0]};
    assign oversize  = 32'(len_full) > $unsigned(MEM_SIZE);

    // Frame FSM with registered write port and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            word_idx  <= '0;
            byte_idx  <= '0;
            len       <= '0;
            csum      <= '0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else if (load_start) begin
            // Restart from any state; previously written memory is left as is.
            state     <= LEN0;
            word_idx  <= '0;
            byte_idx  <= '0;
            len       <= '0;
            csum      <= '0;
            mem_we    <= '0;
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            mem_we <= '0;
            if (accept) begin
                case (state)
                    LEN0: begin
                        len[7:0] <= in_data;
                        state    <= LEN1;
                    end
                    LEN1: begin
                        len[15:8] <= in_data;
                        if (oversize) begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end else if (len_full == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        mem_we    <= LANES'(1) << byte_idx;
                        mem_addr  <= word_idx[MEM_AW-1:0];
                        mem_wdata <= {LANES{LANE_W'(in_data)}};
                        csum      <= csum ^ in_data;
                        if (lane_last) begin
                            byte_idx <= '0;
                            word_idx <= word_nxt;
                        end else begin
                            byte_idx <= byte_idx + BI_W'(1);
                        end
                        if (last_byte) state <= CSUM;
                    end
                    CSUM: begin
                        if (in_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                    default: ;  // ERR drains the host; bytes are dropped
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: frame loads, checksum/length errors,
// restart mid-frame and reset mid-frame, with a byte-lane memory model.
module tb_bram_loader;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [0:SIZE-1];

    bram_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (load_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Byte-enabled memory model fed by the write port.
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (reset_n && mem_we[l]) model[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Present one byte for a single cycle; leaves in_valid high for back-to-back use.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
    endtask

    task automatic idle_bus();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            n_tests++;
            if ({core_hold, in_ready, mem_we, load_done, load_err} !== 8'b1_0_0000_0_0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got hold=%b rdy=%b we=%b done=%b err=%b, want 1 0 0000 0 0",
                         c, core_hold, in_ready, mem_we, load_done, load_err);
            end
            step();
        end
    endtask

    task automatic test_good_frame();
        logic [7:0] pay [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) begin
            send_byte(pay[i]);
            n_tests++;
            if (mem_we !== 4'(1 << (i % 4)) || mem_addr !== 10'(i / 4) || mem_wdata !== {4{pay[i]}}) begin
                n_fail++;
                $display("FAIL good_write %0d: got we=%b addr=%0d wdata=%h, want we=%b addr=%0d wdata=%h",
                         i, mem_we, mem_addr, mem_wdata, 4'(1 << (i % 4)), i / 4, {4{pay[i]}});
            end
        end
        // XOR of 11..88 payload is 0x88
        send_byte(8'h88);
        idle_bus();
        n_tests++;
        if ({load_done, load_err, core_hold, mem_we, in_ready} !== 8'b1_0_0_0000_0) begin
            n_fail++;
            $display("FAIL good_status: got done=%b err=%b hold=%b we=%b rdy=%b, want 1 0 0 0000 0",
                     load_done, load_err, core_hold, mem_we, in_ready);
        end
        step();
        n_tests++;
        if (model[0] !== 32'h44332211 || model[1] !== 32'h88776655) begin
            n_fail++;
            $display("FAIL good_words: got %h %h, want 44332211 88776655", model[0], model[1]);
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] pay [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        pulse_start();
        n_tests++;
        if ({load_done, core_hold} !== 2'b01) begin
            n_fail++;
            $display("FAIL start_clears: got done=%b hold=%b, want 0 1", load_done, core_hold);
        end
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) send_byte(pay[i]);
        send_byte(8'h09);
        n_tests++;
        if ({load_err, load_done, core_hold} !== 3'b101) begin
            n_fail++;
            $display("FAIL bad_csum_status: got err=%b done=%b hold=%b, want 1 0 1", load_err, load_done, core_hold);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA5 + 8'(i);
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL err_drain_ready %0d: got %b, want 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (mem_we !== 4'b0000 || load_err !== 1'b1) begin
                n_fail++;
                $display("FAIL err_drain_nowrite %0d: got we=%b err=%b, want 0000 1", i, mem_we, load_err);
            end
        end
        idle_bus();
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        n_tests++;
        if (mem_we !== 4'b0000) begin
            n_fail++;
            $display("FAIL zero_nowrite: got we=%b, want 0000", mem_we);
        end
        send_byte(8'h00);
        idle_bus();
        n_tests++;
        if ({load_done, load_err, core_hold, mem_we} !== 7'b1_0_0_0000) begin
            n_fail++;
            $display("FAIL zero_done: got done=%b err=%b hold=%b we=%b, want 1 0 0 0000",
                     load_done, load_err, core_hold, mem_we);
        end
    endtask

    task automatic test_oversize();
        pulse_start();
        send_byte(8'h01);   // N = 0x0401 = SIZE + 1
        send_byte(8'h04);
        n_tests++;
        if ({load_err, load_done, core_hold, mem_we} !== 7'b1_0_1_0000) begin
            n_fail++;
            $display("FAIL oversize_err: got err=%b done=%b hold=%b we=%b, want 1 0 1 0000",
                     load_err, load_done, core_hold, mem_we);
        end
        send_byte(8'h12);
        idle_bus();
        n_tests++;
        if (mem_we !== 4'b0000) begin
            n_fail++;
            $display("FAIL oversize_nowrite: got we=%b, want 0000", mem_we);
        end
    endtask

    // N == SIZE is legal; payload byte i is i[7:0], so the XOR is 0x00.
    task automatic test_full_size();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 4 * SIZE; i++) send_byte(8'(i));
        n_tests++;
        if (mem_we !== 4'b1000 || mem_addr !== 10'd1023 || mem_wdata !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL full_last_write: got we=%b addr=%0d wdata=%h, want 1000 1023 ffffffff",
                     mem_we, mem_addr, mem_wdata);
        end
        send_byte(8'h00);
        idle_bus();
        n_tests++;
        if ({load_done, load_err, core_hold} !== 3'b100) begin
            n_fail++;
            $display("FAIL full_done: got done=%b err=%b hold=%b, want 1 0 0", load_done, load_err, core_hold);
        end
        step();
        n_tests++;
        if (model[1023] !== 32'hFFFEFDFC || model[512] !== 32'h03020100) begin
            n_fail++;
            $display("FAIL full_words: got %h %h, want fffefdfc 03020100", model[1023], model[512]);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'hEE;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_ready: got %b, want 0", in_ready);
        end
        @(posedge clk);
        #1;
        load_start = 1'b0;
        idle_bus();
        n_tests++;
        if ({mem_we, load_done, core_hold} !== 6'b0000_0_1) begin
            n_fail++;
            $display("FAIL restart_state: got we=%b done=%b hold=%b, want 0000 0 1", mem_we, load_done, core_hold);
        end
        // Fresh frame 01..08, XOR 0x08, must land at word 0 again.
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1));
            n_tests++;
            if (mem_we !== 4'(1 << (i % 4)) || mem_addr !== 10'(i / 4)) begin
                n_fail++;
                $display("FAIL restart_write %0d: got we=%b addr=%0d, want %b %0d",
                         i, mem_we, mem_addr, 4'(1 << (i % 4)), i / 4);
            end
        end
        send_byte(8'h08);
        idle_bus();
        step();
        n_tests++;
        if (load_done !== 1'b1 || model[0] !== 32'h04030201 || model[1] !== 32'h08070605) begin
            n_fail++;
            $display("FAIL restart_done: got done=%b words %h %h, want 1 04030201 08070605",
                     load_done, model[0], model[1]);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        idle_bus();
        reset_n = 1'b0;   // mid-cycle, while the third write is on the port
        #1;
        n_tests++;
        if ({mem_we, core_hold, in_ready, load_done, load_err} !== 8'b0000_1_0_0_0) begin
            n_fail++;
            $display("FAIL reset_mid: got we=%b hold=%b rdy=%b done=%b err=%b, want 0000 1 0 0 0",
                     mem_we, core_hold, in_ready, load_done, load_err);
        end
        step();
        reset_n = 1'b1;
        step();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got rdy=%b, want 0", in_ready);
        end
        // C0..C7: XOR is 0x00
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i));
        send_byte(8'h00);
        idle_bus();
        step();
        n_tests++;
        if ({load_done, core_hold} !== 2'b10 || model[0] !== 32'hC3C2C1C0 || model[1] !== 32'hC7C6C5C4) begin
            n_fail++;
            $display("FAIL reset_mid_reload: got done=%b hold=%b words %h %h, want 1 0 c3c2c1c0 c7c6c5c4",
                     load_done, core_hold, model[0], model[1]);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        for (int i = 0; i < SIZE; i++) model[i] = 32'h0;
        #1;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_zero_len();
        test_oversize();
        test_full_size();
        test_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
